pipe_stage_elastic: RTL and testbench

//  Parametrised elastic pipeline stage register for the WISC pipeline (ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_elastic.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//
// Elastic pipeline stage register used between the WISC pipeline stages
// (ID/EX, EX/MEM, MEM/WB). Each entry carries a control bundle, NUM_OPS
// operand channels, a destination register index, the PC and a HALT flag.
//
// Storage is a two-entry skid arrangement. MAIN drives every out_* port and
// SKID holds one extra entry, so in_ready can be computed from registered
// state alone with no combinational path from out_ready.
//
// Ports
//   clk, rst          stage clock; synchronous active-high reset
//   in_valid/in_ready upstream handshake (acc = in_valid & in_ready)
//   in_ctrl, in_ops,  incoming entry payload; operand channel k sits at
//   in_rd, in_pc,     in_ops[k*DATA_W +: DATA_W]
//   in_halt
//   stall             hazard freeze: nothing accepted, nothing popped
//   flush             hazard squash: every held entry is discarded
//   out_valid/ready   downstream handshake on the MAIN entry
//   out_ctrl, out_ops,head entry payload; out_rd keeps the last valid dest
//   out_rd, out_pc,   while out_valid is low
//   out_halt
//   halted            sticky, set once a HALT entry has left the stage
//   occupancy         number of entries held (0..2)

module pipe_stage_elastic #(
  parameter int CTRL_W  = 24,
  parameter int DATA_W  = 16,
  parameter int NUM_OPS = 3,
  parameter int RD_W    = 4,
  parameter int PC_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [NUM_OPS*DATA_W-1:0] in_ops,
  input  logic [RD_W-1:0]           in_rd,
  input  logic [PC_W-1:0]           in_pc,
  input  logic                      in_halt,
  input  logic                      stall,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [NUM_OPS*DATA_W-1:0] out_ops,
  output logic [RD_W-1:0]           out_rd,
  output logic [PC_W-1:0]           out_pc,
  output logic                      out_halt,
  output logic                      halted,
  output logic [1:0]                occupancy
);

  localparam int OPS_W   = NUM_OPS * DATA_W;
  localparam int ENTRY_W = CTRL_W + OPS_W + RD_W + PC_W + 1;

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [ENTRY_W-1:0]   main_q, main_d;
  logic [ENTRY_W-1:0]   skid_q, skid_d;
  logic                 halted_q, halted_d;
  logic [ENTRY_W-1:0]   in_entry;
  logic                 acc;
  logic                 pop;

  assign in_entry = {in_ctrl, in_ops, in_rd, in_pc, in_halt};
  assign {out_ctrl, out_ops, out_rd, out_pc, out_halt} = main_q;

  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign halted    = halted_q;

  // Ready depends only on registered state and hazard inputs. It is also
  // held low during reset, since anything offered then is thrown away.
  assign in_ready = ~rst & (state_q != TWO) & ~stall & ~flush & ~halted_q;

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready & ~stall;

  // Next-state and payload selection. Flush beats a HALT leaving the stage,
  // which beats ordinary movement; stall needs no branch of its own because
  // it already forces acc and pop low. Payload registers only ever load from
  // an accepted entry or from SKID, so bubbles never disturb out_rd.
  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    halted_d = halted_q;

    if (flush) begin
      state_d = EMPTY;
    end else if (pop && out_halt) begin
      // Anything behind the HALT (SKID or a same-cycle accept) is dropped.
      halted_d = 1'b1;
      state_d  = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = ONE;
            main_d  = in_entry;
          end
        end
        ONE: begin
          if (acc && !pop) begin
            state_d = TWO;
            skid_d  = in_entry;
          end else if (acc && pop) begin
            main_d  = in_entry;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      halted_q <= halted_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic
//
// Bench for pipe_stage_elastic built with four 32-bit operand channels.
// The driver issues one input vector per cycle and, whenever the reference
// model says the entry is taken, pushes it onto the expected queue. The
// monitor checks the stage outputs against the head of that queue on every
// falling edge and pops it when the downstream handshake completes.

module tb_pipe_stage_elastic;

  localparam int CTRL_W  = 24;
  localparam int DATA_W  = 32;
  localparam int NUM_OPS = 4;
  localparam int RD_W    = 4;
  localparam int PC_W    = 16;
  localparam int OPS_W   = NUM_OPS * DATA_W;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [OPS_W-1:0]  ops;
    logic [RD_W-1:0]   rd;
    logic [PC_W-1:0]   pc;
    logic              halt;
  } entry_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [OPS_W-1:0]  in_ops;
  logic [RD_W-1:0]   in_rd;
  logic [PC_W-1:0]   in_pc;
  logic              in_halt;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [OPS_W-1:0]  out_ops;
  logic [RD_W-1:0]   out_rd;
  logic [PC_W-1:0]   out_pc;
  logic              out_halt;
  logic              halted;
  logic [1:0]        occupancy;

  // Reference model: the queue of entries the stage should hold, oldest
  // first, plus the sticky halt flag and the last destination shown.
  entry_t          exp_q[$];
  bit              ref_halted;
  logic [RD_W-1:0] ref_last_rd;
  bit              ready_rec;
  bit              rst_prev;

  int checks;
  int fails;

  pipe_stage_elastic #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W),
    .NUM_OPS(NUM_OPS),
    .RD_W   (RD_W),
    .PC_W   (PC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_ops   (in_ops),
    .in_rd    (in_rd),
    .in_pc    (in_pc),
    .in_halt  (in_halt),
    .stall    (stall),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_ops  (out_ops),
    .out_rd   (out_rd),
    .out_pc   (out_pc),
    .out_halt (out_halt),
    .halted   (halted),
    .occupancy(occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports a mismatch with both values.
  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge, records whether
  // the model expects the entry to be taken, and late in the cycle (after the
  // monitor has retired any pop) pushes the accepted entry. A HALT leaving in
  // the same cycle discards the accepted entry, hence the ref_halted test.
  task automatic applyStimulus(input bit r, input bit v, input logic [PC_W-1:0] pc,
                               input logic [RD_W-1:0] rd, input bit hlt,
                               input bit st, input bit fl, input bit ordy,
                               input logic [CTRL_W-1:0] ctrl,
                               input logic [OPS_W-1:0] ops);
    entry_t e;
    @(posedge clk);
    #1;
    rst       = r;
    in_valid  = v;
    in_pc     = pc;
    in_rd     = rd;
    in_halt   = hlt;
    stall     = st;
    flush     = fl;
    out_ready = ordy;
    in_ctrl   = ctrl;
    in_ops    = ops;
    ready_rec = !r && (exp_q.size() < 2) && !st && !fl && !ref_halted;
    #6;
    if (v && ready_rec && !ref_halted) begin
      e.ctrl = ctrl;
      e.ops  = ops;
      e.rd   = rd;
      e.pc   = pc;
      e.halt = hlt;
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [OPS_W-1:0] randOps();
    logic [OPS_W-1:0] o;
    for (int k = 0; k < NUM_OPS; k++) o[k*DATA_W +: DATA_W] = $urandom;
    return o;
  endfunction

  // Monitor: compares outputs with the model each falling edge, then applies
  // the flush / pop / halt effects the coming rising edge will have.
  initial begin
    entry_t head;
    rst_prev = 1'b1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst) begin
        checkOutput("rst_in_ready", in_ready, 0);
        if (rst_prev) begin
          checkOutput("rst_out_valid", out_valid, 0);
          checkOutput("rst_occupancy", occupancy, 0);
          checkOutput("rst_halted", halted, 0);
          checkOutput("rst_out_rd", out_rd, 0);
          checkOutput("rst_out_pc", out_pc, 0);
        end
        exp_q.delete();
        ref_halted  = 1'b0;
        ref_last_rd = '0;
      end else begin
        checkOutput("in_ready", in_ready,
                    (exp_q.size() < 2) && !stall && !flush && !ref_halted);
        checkOutput("occupancy", occupancy, exp_q.size());
        checkOutput("out_valid", out_valid, exp_q.size() != 0);
        checkOutput("halted", halted, ref_halted);
        if (exp_q.size() != 0) begin
          checkOutput("out_rd", out_rd, exp_q[0].rd);
          checkOutput("out_pc", out_pc, exp_q[0].pc);
          checkOutput("out_ctrl", out_ctrl, exp_q[0].ctrl);
          checkOutput("out_ops", out_ops, exp_q[0].ops);
          checkOutput("out_halt", out_halt, exp_q[0].halt);
          ref_last_rd = exp_q[0].rd;
        end else begin
          checkOutput("out_rd_held", out_rd, ref_last_rd);
        end
        if (flush) begin
          exp_q.delete();
        end else if (exp_q.size() != 0 && out_ready && !stall) begin
          head = exp_q.pop_front();
          if (head.halt) begin
            ref_halted = 1'b1;
            exp_q.delete();
          end
        end
      end
      rst_prev = rst;
    end
  end

  // Stimulus: directed scenarios followed by a randomized run.
  initial begin
    bit r, v, h, st, fl, ordy;
    logic [OPS_W-1:0] wide_ops;
    checks    = 0;
    fails     = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = '0;
    in_ops    = '0;
    in_rd     = '0;
    in_pc     = '0;
    in_halt   = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    ready_rec = 1'b0;

    $display("[TB] reset with in_valid held high");
    applyStimulus(1, 1, 16'h00AA, 4'd9, 0, 0, 0, 1, 24'h123456, randOps());

    $display("[TB] streaming eight entries");
    for (int i = 0; i < 8; i++)
      applyStimulus(0, 1, 16'(i), 4'(i + 1), 0, 0, 0, 1, 24'($urandom), randOps());
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    $display("[TB] skid capture and drain");
    applyStimulus(0, 1, 16'h00A0, 4'd3, 0, 0, 0, 0, 24'hAAAAAA, randOps());
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 16'h00B0, 4'd5, 0, 0, 0, 0, 24'hBBBBBB, 128'hB);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    $display("[TB] stall then stall with flush");
    applyStimulus(0, 1, 16'h00C0, 4'd5, 0, 0, 0, 0, 24'hCCCCCC, randOps());
    applyStimulus(0, 1, 16'h00C1, 4'd9, 0, 0, 0, 0, 24'hDDDDDD, randOps());
    applyStimulus(0, 1, 16'h00C2, 4'd1, 0, 1, 0, 1, 24'hEEEEEE, randOps());
    applyStimulus(0, 1, 16'h00C3, 4'd2, 0, 1, 0, 1, 24'hEEEEEE, randOps());
    applyStimulus(0, 1, 16'h00C4, 4'd2, 0, 1, 1, 1, 24'hEEEEEE, randOps());
    applyStimulus(0, 0, 0, 4'd7, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 4'd7, 0, 0, 0, 1, 0, 0);

    $display("[TB] wide operand channels");
    wide_ops = {32'h00000004, 32'h00000003, 32'h00000002, 32'hDEADBEEF};
    applyStimulus(0, 1, 16'h0020, 4'd6, 0, 0, 0, 1, 24'h0F0F0F, wide_ops);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    $display("[TB] halt becomes sticky");
    applyStimulus(0, 1, 16'h0010, 4'd4, 1, 0, 0, 0, 24'h000001, randOps());
    applyStimulus(0, 1, 16'h0011, 4'd8, 0, 0, 0, 0, 24'h000002, randOps());
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus(0, i[0], 16'h0012, 4'd9, 0, 0, 0, 1, 24'h000003, randOps());
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      r    = ref_halted && ($urandom_range(0, 3) == 0);
      v    = ($urandom_range(0, 9) < 7);
      h    = ($urandom_range(0, 39) == 0);
      st   = ($urandom_range(0, 9) == 0);
      fl   = ($urandom_range(0, 24) == 0);
      ordy = ($urandom_range(0, 9) < 6);
      applyStimulus(r, v, 16'($urandom), 4'($urandom), h, st, fl, ordy,
                    24'($urandom), randOps());
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
